// File: rtl/alu_seq_param_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
package alu_seq_param_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_iter_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step.
module alu_iter_step
  import alu_seq_param_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]     op,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] acc_next,
  output logic           q_bit
);

  logic [W:0] sum;
  logic [W:0] rem_sh;
  logic [W:0] trial;

  // mul: acc = {partial product, remaining multiplier bits}
  assign sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});

  // div: acc = {partial remainder, remaining dividend bits}; trial[W] is the borrow
  assign rem_sh = acc[2*W-1:W-1];
  assign trial  = rem_sh - {1'b0, operand};

  always_comb begin
    acc_next = acc;
    q_bit    = 1'b0;
    if (op == OP_MUL) begin
      acc_next = {sum, acc[W-1:1]};
    end else if (op == OP_DIV) begin
      if (!trial[W]) begin
        q_bit    = 1'b1;
        acc_next = {trial[W-1:0], acc[W-2:0], 1'b0};
      end else begin
        acc_next = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// Sequential add/sub/mul/div ALU with start/busy/done handshake.
// state  | meaning
// IDLE   | waiting for start, last result held
// CALC   | operation in progress (1 or W cycles)
// DONE   | single-cycle result-valid pulse, start may chain the next op
module alu_seq_param
  import alu_seq_param_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     opcode,
  input  logic [W-1:0]   portA,
  input  logic [W-1:0]   portB,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           neg,
  output logic           err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_next;
  logic [2*W-1:0]   acc_step;
  logic             q_bit;
  logic [W:0]       add_sum;
  logic             accept;

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign add_sum  = {1'b0, a_r} + {1'b0, b_r};
  assign acc_step = acc_next | {{(2*W-1){1'b0}}, q_bit};

  alu_iter_step #(.W(W)) u_step (
    .op       (op_r),
    .acc      (acc),
    .operand  ((op_r == OP_MUL) ? a_r : b_r),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_r   <= OP_ADD;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state <= S_CALC;
            busy  <= 1'b1;
            neg   <= 1'b0;
            err   <= 1'b0;
            op_r  <= opcode;
            a_r   <= portA;
            b_r   <= portB;
            cnt   <= CNT_LAST;
            acc   <= (opcode == OP_MUL) ? {{W{1'b0}}, portB} : {{W{1'b0}}, portA};
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          case (op_r)
            OP_ADD: begin
              result <= {{(W-1){1'b0}}, add_sum};
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
            OP_SUB: begin
              if (a_r < b_r) begin
                result <= {{W{1'b0}}, b_r - a_r};
                neg    <= 1'b1;
              end else begin
                result <= {{W{1'b0}}, a_r - b_r};
              end
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            default: begin
              if (op_r == OP_DIV && b_r == '0) begin
                err    <= 1'b1;
                result <= '1;
                state  <= S_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                acc <= acc_step;
                if (cnt == '0) begin
                  result <= acc_step;
                  state  <= S_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                end else begin
                  cnt <= cnt - 1'b1;
                end
              end
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed-vector bench for alu_seq_param at W=8.
module tb_alu_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  opcode;
  logic [7:0]  portA;
  logic [7:0]  portB;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        neg;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_seq_param #(.W(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opcode (opcode),
    .portA  (portA),
    .portB  (portB),
    .busy   (busy),
    .done   (done),
    .result (result),
    .neg    (neg),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // returns edges after the accept edge until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  // latency counts the accept edge as edge 1
  task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int exp_lat, input logic [15:0] exp_res,
                       input logic exp_neg, input logic exp_err);
    int n;
    @(negedge clk);
    opcode = op; portA = a; portB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_flags_clr"}, {neg, err, done}, 0);
    wait_done(n);
    chk({tag, "_lat"}, n + 1, exp_lat);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_neg"}, neg, exp_neg);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {done, busy}, 0);
    chk({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int n;
    int ndone;
    rst = 1'b0; start = 1'b0; opcode = 2'b00; portA = '0; portB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {busy, done, neg, err}, 0);
    chk("rst_res", result, 0);
    @(negedge clk); rst = 1'b1;

    do_op("add1", 2'b00, 8'd200, 8'd100, 2, 16'h012C, 0, 0);
    do_op("add2", 2'b00, 8'd255, 8'd255, 2, 16'h01FE, 0, 0);
    do_op("sub1", 2'b01, 8'd5,   8'd9,   2, 16'h0004, 1, 0);
    do_op("sub2", 2'b01, 8'd9,   8'd5,   2, 16'h0004, 0, 0);
    do_op("sub3", 2'b01, 8'd7,   8'd7,   2, 16'h0000, 0, 0);
    do_op("mul1", 2'b10, 8'd255, 8'd255, 9, 16'hFE01, 0, 0);
    do_op("mul2", 2'b10, 8'd13,  8'd11,  9, 16'h008F, 0, 0);
    do_op("mul3", 2'b10, 8'd0,   8'd77,  9, 16'h0000, 0, 0);
    do_op("div1", 2'b11, 8'd200, 8'd7,   9, 16'h041C, 0, 0);
    do_op("div0", 2'b11, 8'd7,   8'd0,   2, 16'hFFFF, 0, 1);
    do_op("div2", 2'b11, 8'd255, 8'd1,   9, 16'h00FF, 0, 0);
    do_op("div3", 2'b11, 8'd3,   8'd200, 9, 16'h0300, 0, 0);

    // start held through a mul, operands and opcode disturbed mid-CALC
    @(negedge clk);
    opcode = 2'b10; portA = 8'd13; portB = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (n == 3) begin portA = 8'd1; portB = 8'd1; opcode = 2'b00; end
    end
    start = 1'b0;
    chk("held_lat", n + 1, 9);
    chk("held_res", result, 16'h008F);
    ndone = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("held_ndone", ndone, 1);

    // back-to-back start in the DONE cycle
    @(negedge clk);
    opcode = 2'b00; portA = 8'd1; portB = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("b2b_first", result, 16'h0003);
    opcode = 2'b10; portA = 8'd3; portB = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_nogap", {busy, done}, 2'b10);
    wait_done(n);
    chk("b2b_lat", n + 1, 9);
    chk("b2b_res", result, 16'h000C);

    // reset in CALC cycle 4 of a mul
    @(negedge clk);
    opcode = 2'b10; portA = 8'd255; portB = 8'd255; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_outs", {busy, done, neg, err}, 0);
    chk("abort_res", result, 0);
    @(negedge clk); rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_quiet", ndone, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
